// File: rtl/onchip_mem_arb_pkg.sv
// Shared types and default geometry for the two-port on-chip memory arbiter.
package onchip_mem_arb_pkg;

  localparam int unsigned DEF_DEPTH = 8000;
  localparam int unsigned DEF_AW    = 13;
  localparam int unsigned DEF_DW    = 32;

  typedef logic port_id_t;

  // First read-return stage: issued-read marker, owning port and out-of-range flag.
  typedef struct packed {
    logic     valid;
    port_id_t owner;
    logic     oor;
  } rd_stage_t;

endpackage

// File: rtl/onchip_mem_arbiter_rr_arb2.sv
// Two-requester round-robin grant; on a tie the port that did not win last time wins.
module rr_arb2
  import onchip_mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  port_id_t last_grant_q;
  port_id_t last_grant_d;

  always_comb begin
    gnt = '0;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_grant_q == 1'b1) ? 2'b01 : 2'b10;
      default: gnt = '0;
    endcase
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (advance) begin
      last_grant_d = gnt[1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Shares one single-port on-chip memory between two Avalon-MM masters with
// round-robin grant and a two-stage registered read-return path.
module onchip_mem_arbiter
  import onchip_mem_arb_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned AW    = DEF_AW,
  parameter int unsigned DW    = DEF_DW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   m0_address,
  input  logic [DW/8-1:0] m0_byteenable,
  input  logic            m0_read,
  input  logic            m0_write,
  input  logic [DW-1:0]   m0_writedata,
  output logic            m0_waitrequest,
  output logic [DW-1:0]   m0_readdata,
  output logic            m0_readdatavalid,
  input  logic [AW-1:0]   m1_address,
  input  logic [DW/8-1:0] m1_byteenable,
  input  logic            m1_read,
  input  logic            m1_write,
  input  logic [DW-1:0]   m1_writedata,
  output logic            m1_waitrequest,
  output logic [DW-1:0]   m1_readdata,
  output logic            m1_readdatavalid,
  output logic [AW-1:0]   mem_address,
  output logic [DW/8-1:0] mem_byteenable,
  output logic [DW-1:0]   mem_writedata,
  output logic            mem_chipselect,
  output logic            mem_write,
  output logic            mem_clken,
  input  logic [DW-1:0]   mem_readdata
);

  logic [1:0] req;
  logic [1:0] gnt;
  logic       granted;
  port_id_t   sel;
  logic       sel_write;
  logic       oor;

  rd_stage_t  s1_q, s1_d;
  logic       s2_valid_q, s2_valid_d;
  port_id_t   s2_owner_q, s2_owner_d;
  logic [DW-1:0] rdata_q, rdata_d;

  // Requests are masked in reset so nothing is granted and last_grant holds.
  assign req = reset ? 2'b00 : {m1_read | m1_write, m0_read | m0_write};

  rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .advance (granted),
    .gnt     (gnt)
  );

  always_comb begin
    granted        = |gnt;
    sel            = gnt[1];
    mem_address    = sel ? m1_address    : m0_address;
    mem_byteenable = sel ? m1_byteenable : m0_byteenable;
    mem_writedata  = sel ? m1_writedata  : m0_writedata;
    sel_write      = sel ? m1_write      : m0_write;
    oor            = 32'(mem_address) >= DEPTH;
    mem_chipselect = granted & ~oor;
    mem_write      = mem_chipselect & sel_write;
    mem_clken      = ~reset;
    m0_waitrequest = reset | (req[0] & ~gnt[0]);
    m1_waitrequest = reset | (req[1] & ~gnt[1]);
  end

  always_comb begin
    s1_d       = '{valid: granted & ~sel_write, owner: sel, oor: oor};
    s2_valid_d = s1_q.valid;
    s2_owner_d = s1_q.owner;
    rdata_d    = s1_q.oor ? '0 : mem_readdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q       <= '0;
      s2_valid_q <= 1'b0;
      s2_owner_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      s1_q       <= s1_d;
      s2_valid_q <= s2_valid_d;
      s2_owner_q <= s2_owner_d;
      rdata_q    <= rdata_d;
    end
  end

  assign m0_readdatavalid = s2_valid_q & (s2_owner_q == 1'b0);
  assign m1_readdatavalid = s2_valid_q & (s2_owner_q == 1'b1);
  assign m0_readdata      = rdata_q;
  assign m1_readdata      = rdata_q;

endmodule
